// File: rtl/cube_regs_axil_slave.sv
// AXI4-Lite register file for the cube interface: NUM_REGS 32-bit registers with
// independent AW/W acceptance, byte strobes, out-of-range SLVERR and a cube-side write port.
module cube_regs_axil_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS-1:0]            hw_wr_en,
  input  logic [DATA_WIDTH-1:0]          hw_wr_data
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < (IDX_W + 1)'(NUM_REGS));
  endfunction

  logic                           aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d;
  logic                           w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [STRB_W-1:0]              wstrb_q, wstrb_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic                           rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            pulse_q, pulse_d;

  logic                  awready_s, wready_s, arready_s;
  logic                  aw_fire_s, w_fire_s, ar_fire_s, commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [STRB_W-1:0]     wr_strb_s;
  logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
  logic                  unused_s;

  // Ready gating also holds every ready low while reset is asserted
  assign awready_s = !ARESET && !aw_held_q && !bvalid_q;
  assign wready_s  = !ARESET && !w_held_q && !bvalid_q;
  assign arready_s = !ARESET && !rvalid_q;
  assign aw_fire_s = S_AXI_AWVALID && awready_s;
  assign w_fire_s  = S_AXI_WVALID && wready_s;
  assign ar_fire_s = S_AXI_ARVALID && arready_s;
  assign commit_s  = (aw_held_q || aw_fire_s) && (w_held_q || w_fire_s);
  assign wr_addr_s = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wr_data_s = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb_s = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_idx_s  = wr_addr_s[ADDR_WIDTH-1:2];
  assign rd_idx_s  = S_AXI_ARADDR[IDX_W+1:2];
  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr_s[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      if (hw_wr_en[i]) begin
        regs_d[i*DATA_WIDTH +: DATA_WIDTH] = hw_wr_data;
      end else begin
        regs_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // AXI bytes are applied after the hw write so strobed bytes take priority
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = idx_in_range(wr_idx_s) ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_in_range(wr_idx_s) && (wr_idx_s == IDX_W'(i))) begin
          pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb_s[k]) begin
              regs_d[i*DATA_WIDTH + k*8 +: 8] = wr_data_s[k*8 +: 8];
            end else begin
              regs_d[i*DATA_WIDTH + k*8 +: 8] = regs_d[i*DATA_WIDTH + k*8 +: 8];
            end
          end
        end else begin
          pulse_d[i] = 1'b0;
        end
      end
    end else begin
      if (aw_fire_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = S_AXI_AWADDR;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_fire_s) begin
        w_held_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end else begin
        w_held_d = w_held_q;
      end
    end
  end

  // Read data is captured from the pre-commit register state on the AR handshake
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire_s) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = idx_in_range(rd_idx_s) ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_idx_s == IDX_W'(i)) begin
          rdata_d = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          rdata_d = rdata_d;
        end
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end

  assign S_AXI_AWREADY = awready_s;
  assign S_AXI_WREADY  = wready_s;
  assign S_AXI_ARREADY = arready_s;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_q         = regs_q;
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_cube_regs_axil_slave.sv
// Directed bench for cube_regs_axil_slave: AXI4-Lite writes/reads, strobes,
// out-of-range decode, backpressure, hw-port collisions and mid-transaction reset.
module tb_cube_regs_axil_slave;

  logic         clk = 1'b0;
  logic         areset;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata, hw_wr_data;
  logic [3:0]   wstrb, reg_wr_pulse, hw_wr_en;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_q;

  int n_cmp = 0;
  int n_err = 0;

  cube_regs_axil_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int budget  = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && budget < 20) begin
      logic awr, wr;
      awr = awready;
      wr  = wready;
      step();
      budget++;
      if (awr && awvalid) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (wr && wvalid) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_handshake", {aw_done, w_done}, 2'b11);
    budget = 0;
    while (!bvalid && budget < 20) begin step(); budget++; end
    check_eq("wr_bvalid", bvalid, 1'b1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done = 1'b0;
    int budget  = 0;
    araddr = a; arvalid = 1'b1;
    while (!ar_done && budget < 20) begin
      logic arr;
      arr = arready;
      step();
      budget++;
      if (arr) begin ar_done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    budget = 0;
    while (!rvalid && budget < 20) begin step(); budget++; end
    check_eq("rd_rvalid", {ar_done, rvalid}, 2'b11);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [127:0] exp_regs;

    areset = 1'b1;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    hw_wr_en = '0; hw_wr_data = '0;

    step(); step();
    check_eq("rst_ready", {awready, wready, arready}, 3'b000);
    check_eq("rst_valid", {bvalid, rvalid}, 2'b00);
    check_eq("rst_regs", reg_q, 128'h0);
    check_eq("rst_data_resp", {rdata, bresp, rresp, reg_wr_pulse}, 40'h0);
    areset = 1'b0;
    step();
    check_eq("post_rst_ready", {awready, wready, arready}, 3'b111);

    // Basic write then read of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      check_eq("t1_bresp", resp, 2'b00);
    end
    check_eq("t1_regs", reg_q, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), rd, resp);
      check_eq("t1_rdata", rd, 32'(i + 1));
      check_eq("t1_rresp", resp, 2'b00);
    end

    // W three cycles ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check_eq("t2_wready_held", wready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_no_bvalid", {bvalid, reg_wr_pulse}, 5'b0_0000);
      step();
    end
    awaddr = 5'h04; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check_eq("t2_bvalid", {bvalid, bresp}, 3'b1_00);
    check_eq("t2_pulse", reg_wr_pulse, 4'b0010);
    check_eq("t2_reg1", reg_q[63:32], 32'hDEADBEEF);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check_eq("t2_pulse_off", {bvalid, reg_wr_pulse}, 5'b0_0000);

    // Byte strobes
    axi_write(5'h08, 32'h11223344, 4'hF, resp);
    axi_write(5'h08, 32'hAABBCCDD, 4'b0101, resp);
    check_eq("t3_reg2", reg_q[95:64], 32'h11BB33DD);

    // Out of range
    exp_regs = {32'd4, 32'h11BB33DD, 32'hDEADBEEF, 32'd1};
    axi_write(5'h10, 32'h55555555, 4'hF, resp);
    check_eq("t4_bresp", resp, 2'b10);
    check_eq("t4_regs", reg_q, exp_regs);
    axi_read(5'h10, rd, resp);
    check_eq("t4_rdata", rd, 32'h0);
    check_eq("t4_rresp", resp, 2'b10);

    // Backpressure with a same-edge read/write of reg3 (read sees old value)
    awaddr = 5'h0C; wdata = 32'h000000C5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h0C; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("t5_flags", {bvalid, rvalid, awready, wready, arready}, 5'b11000);
      check_eq("t5_rdata", {rdata, rresp, bresp}, {32'd4, 2'b00, 2'b00});
      step();
    end
    check_eq("t5_reg3", reg_q[127:96], 32'h000000C5);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check_eq("t5_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

    // hw write and AXI write to reg0 on the same edge
    hw_wr_en = 4'b0001; hw_wr_data = 32'hFFFFFFFF;
    awaddr = 5'h00; wdata = 32'h0; wstrb = 4'b0011; awvalid = 1'b1; wvalid = 1'b1;
    step();
    hw_wr_en = 4'b0000; awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t6_reg0", reg_q[31:0], 32'hFFFF0000);
    check_eq("t6_pulse", {bvalid, reg_wr_pulse}, 5'b1_0001);
    bready = 1'b1;
    step();
    bready = 1'b0;
    hw_wr_en = 4'b0100; hw_wr_data = 32'hCAFEF00D;
    step();
    hw_wr_en = 4'b0000;
    check_eq("t6_hw_reg2", reg_q[95:64], 32'hCAFEF00D);
    check_eq("t6_hw_no_pulse", reg_wr_pulse, 4'b0000);

    // Reset after AW only; a later lone W must not complete a write
    awaddr = 5'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check_eq("t7_aw_held", awready, 1'b0);
    areset = 1'b1;
    step();
    check_eq("t7_rst_regs", reg_q, 128'h0);
    check_eq("t7_rst_flags", {awready, wready, arready, bvalid, rvalid, reg_wr_pulse}, 9'h0);
    check_eq("t7_rst_data", {rdata, bresp, rresp}, 36'h0);
    areset = 1'b0;
    step();
    wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check_eq("t7_w_held", {wready, awready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check_eq("t7_no_bvalid", {bvalid, reg_wr_pulse}, 5'b0_0000);
      step();
    end
    check_eq("t7_regs", reg_q, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
